mc_pipe_sdff: RTL

MC_PIPE_SDFF -- requirements
Module: mc_pipe_sdff

---
 rtl/mc_pkg.sv | 11 +
 rtl/mc_pipe_stage.sv | 34 +++
 rtl/mc_pipe_sdff.sv | 83 ++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: legal parameter ranges and the occupancy-counter width helper shared by the mc_pipe_sdff files.
package mc_pkg;
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 16;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/mc_pipe_stage.sv
// mc_pipe_stage: one pipeline slot with a data register, a valid bit, a sync reset and a load enable.
module mc_pipe_stage
    import mc_pkg::*;
#(
    parameter int               WIDTH      = 1,
    parameter logic [WIDTH-1:0] SRST_VALUE = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             SRST,
    input  logic             i_load,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_valid
);
    logic [WIDTH-1:0] r_q;
    logic             r_valid;

    // Loading wins over clearing so a stage that passes a word on and takes a new one stays full.
    always_ff @(posedge CLK) begin
        if (SRST) begin
            r_q     <= SRST_VALUE;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_q     <= i_d;
            r_valid <= 1'b1;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end
    end

    assign o_q     = r_q;
    assign o_valid = r_valid;
endmodule

// File: rtl/mc_pipe_sdff.sv
// mc_pipe_sdff: valid/ready register pipeline of DEPTH stages with bubble collapse and sync reset.
// Define MC_PIPE_OCC_EN to add the OCC port reporting the number of valid stages.
module mc_pipe_sdff
    import mc_pkg::*;
#(
    parameter int               WIDTH      = 1,
    parameter int               DEPTH      = 2,
    parameter logic [WIDTH-1:0] SRST_VALUE = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             SRST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] D,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Q
`ifdef MC_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] OCC
`endif
);
    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_load;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic [WIDTH-1:0] w_din  [DEPTH];
    logic             w_in_hs;

    // Readiness ripples from the output end back to the input so bubbles collapse in one cycle.
    always_comb begin
        w_adv            = '0;
        w_adv[DEPTH-1]   = w_valid[DEPTH-1] & OUT_READY;
        for (int i = DEPTH - 2; i >= 0; i--)
            w_adv[i] = w_valid[i] & (!w_valid[i+1] | w_adv[i+1]);
        w_load    = '0;
        w_load[0] = w_in_hs;
        w_din[0]  = D;
        for (int i = 1; i < DEPTH; i++) begin
            w_load[i] = w_adv[i-1];
            w_din[i]  = w_data[i-1];
        end
    end

    assign IN_READY  = !SRST & (!w_valid[0] | w_adv[0]);
    assign w_in_hs   = IN_VALID & IN_READY;
    assign OUT_VALID = w_valid[DEPTH-1];
    assign Q         = w_data[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        mc_pipe_stage #(
            .WIDTH     (WIDTH),
            .SRST_VALUE(SRST_VALUE)
        ) u_stage (
            .CLK    (CLK),
            .SRST   (SRST),
            .i_load (w_load[i]),
            .i_clr  (w_adv[i]),
            .i_d    (w_din[i]),
            .o_q    (w_data[i]),
            .o_valid(w_valid[i])
        );
    end

`ifdef MC_PIPE_OCC_EN
    localparam int OW = occ_width(DEPTH);
    logic          w_out_hs;
    logic [OW-1:0] r_occ;

    assign w_out_hs = OUT_VALID & OUT_READY;

    always_ff @(posedge CLK) begin
        if (SRST)
            r_occ <= '0;
        else if (w_in_hs & !w_out_hs)
            r_occ <= r_occ + OW'(1);
        else if (!w_in_hs & w_out_hs)
            r_occ <= r_occ - OW'(1);
    end

    assign OCC = r_occ;
`endif
endmodule
